// File: rtl/is_pkg.sv
// Shared types and constants for the IS tile IO translation path.
//   state_t  : io_tlb controller states
//   entry_t  : one translation entry {valid, asid, vpn, size, content}
//   PTE_*    : flag bit positions inside content[9:0]
package is_pkg;

   localparam int L15_PADDR_HI = 39;
   localparam int PADDR_W      = L15_PADDR_HI + 1;
   localparam int PTE_ADDR     = 28;
   localparam int PTE_WIDTH    = 38;
   localparam int VPN_W        = 27;
   // Entries store the ASID zero-extended to this width, so any ASID_WIDTH up to it fits.
   localparam int ASID_MAX     = 16;

   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WALK,
      ST_RESP,
      ST_DRAIN
   } state_t;

   // size: bit 1 = 1G page, bit 0 = 2M page, 00 = 4K page.
   // content: {ppn[27:0], flags[9:0]}
   typedef struct packed {
      logic                 valid;
      logic [ASID_MAX-1:0]  asid;
      logic [VPN_W-1:0]     vpn;
      logic [1:0]           size;
      logic [PTE_WIDTH-1:0] content;
   } entry_t;

endpackage

// File: rtl/io_tlb_match.sv
// Per-entry compare and physical address formation (combinational).
//   entry    : stored translation
//   vpn      : request VPN (va[38:12])
//   asid     : request ASID, zero-extended
//   va_low   : request va[29:0], the widest page offset
//   hit      : entry matches (valid, ASID or global, VPN at entry size)
//   store_ok : entry permits a store (W and D set)
//   paddr    : translated address assuming this entry is used
module io_tlb_match
   import is_pkg::*;
(
   input  entry_t                entry,
   input  logic [VPN_W-1:0]      vpn,
   input  logic [ASID_MAX-1:0]   asid,
   input  logic [29:0]           va_low,
   output logic                  hit,
   output logic                  store_ok,
   output logic [PADDR_W-1:0]    paddr
);

   logic [PTE_ADDR-1:0] ppn;
   logic [9:0]          flags;
   logic                asid_ok;
   logic                vpn_ok;

   assign ppn     = entry.content[PTE_WIDTH-1:10];
   assign flags   = entry.content[9:0];
   assign asid_ok = (entry.asid == asid) || flags[PTE_G];

   always_comb begin
      vpn_ok = (entry.vpn == vpn);
      paddr  = {ppn, va_low[11:0]};
      if (entry.size[1]) begin
         vpn_ok = (entry.vpn[26:18] == vpn[26:18]);
         paddr  = {ppn[27:18], va_low[29:0]};
      end else if (entry.size[0]) begin
         vpn_ok = (entry.vpn[26:9] == vpn[26:9]);
         paddr  = {ppn[27:9], va_low[20:0]};
      end
   end

   assign hit      = entry.valid && asid_ok && vpn_ok;
   assign store_ok = flags[PTE_W] && flags[PTE_D];

   logic unused_flags;
   assign unused_flags = ^{flags[9:8], flags[PTE_A], flags[PTE_U], flags[PTE_X],
                           flags[PTE_R], flags[PTE_V]};

endmodule

// File: rtl/io_tlb.sv
// Fully associative IOMMU TLB between the IO device request port and io_ptw.
// Translates Sv39 virtual addresses to 40-bit physical addresses; misses are
// handed to the PTW through tlb_access/update and completed after the fill.
//   clk_i, rst_ni                 : clock, async active-low reset
//   flush_i                       : invalidate all entries, drop in-flight request
//   tlb_en_i, asid_i              : translation enable (0 = bypass), current ASID
//   req_*                         : device request handshake, vaddr, store flag
//   resp_*                        : response handshake, paddr, fault
//   tlb_access_o/tlb_hit_o/tlb_vaddr_o/is_store_o : lookup strobe to PTW
//   update_*                      : PTW fill port, update_rdy_o when a fill is accepted
//   ptw_active_i, ptw_error_i     : PTW busy, walk failed
//
// state  | meaning
// IDLE   | ready for a device request
// LOOKUP | one-cycle compare against all entries, strobes the PTW
// WALK   | miss outstanding, waiting for a fill or a PTW error
// RESP   | response held until accepted
// DRAIN  | flushed mid-walk, waiting for the PTW to go idle; fills ignored
module io_tlb
   import is_pkg::*;
#(
   parameter int TLB_ENTRIES = 8,
   parameter int ASID_WIDTH  = 1,
   parameter int VADDR       = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    tlb_en_i,
   input  logic [ASID_WIDTH-1:0]   asid_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [VADDR-1:0]        req_vaddr_i,
   input  logic                    req_is_store_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [L15_PADDR_HI:0]   resp_paddr_o,
   output logic                    resp_error_o,
   output logic                    tlb_access_o,
   output logic                    tlb_hit_o,
   output logic [VADDR-1:0]        tlb_vaddr_o,
   output logic                    is_store_o,
   output logic                    update_rdy_o,
   input  logic                    update_valid_i,
   input  logic [1:0]              update_size_i,
   input  logic [VPN_W-1:0]        update_vpn_i,
   input  logic [ASID_WIDTH-1:0]   update_asid_i,
   input  logic [PTE_WIDTH-1:0]    update_content_i,
   input  logic                    ptw_active_i,
   input  logic                    ptw_error_i
);

   localparam int IDX_W = $clog2(TLB_ENTRIES);

   state_t                 state_q, state_d;
   entry_t                 tlb_q [TLB_ENTRIES];
   logic [VADDR-1:0]       vaddr_q;
   logic                   is_store_q;
   logic [ASID_MAX-1:0]    asid_q;
   logic [PADDR_W-1:0]     paddr_q, paddr_d;
   logic                   error_q, error_d;
   logic [IDX_W-1:0]       rr_q;

   logic [TLB_ENTRIES-1:0] match;
   logic [TLB_ENTRIES-1:0] store_ok;
   logic [TLB_ENTRIES-1:0] valid_vec;
   logic [PADDR_W-1:0]     paddr_e [TLB_ENTRIES];
   logic [IDX_W-1:0]       hit_idx;
   logic [IDX_W-1:0]       victim;
   logic                   lookup_hit;
   logic                   full;
   logic                   accept;
   logic                   fill_en;

   for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_entry
      io_tlb_match u_match (
         .entry    (tlb_q[g]),
         .vpn      (vaddr_q[38:12]),
         .asid     (asid_q),
         .va_low   (vaddr_q[29:0]),
         .hit      (match[g]),
         .store_ok (store_ok[g]),
         .paddr    (paddr_e[g])
      );
      assign valid_vec[g] = tlb_q[g].valid;
   end

   // Lowest-index match wins; lowest-index free slot is the fill victim.
   always_comb begin
      hit_idx = '0;
      victim  = rr_q;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (match[i])         hit_idx = IDX_W'(i);
         if (!valid_vec[i])    victim  = IDX_W'(i);
      end
   end

   assign full       = &valid_vec;
   // A store to a non-writable/clean page looks like a miss so the PTW walks and faults.
   assign lookup_hit = (|match) && !(is_store_q && !store_ok[hit_idx]);
   assign fill_en    = (state_q == ST_WALK) && update_valid_i && !flush_i;

   always_comb begin
      state_d      = state_q;
      paddr_d      = paddr_q;
      error_d      = error_q;
      accept       = 1'b0;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      tlb_access_o = 1'b0;
      tlb_hit_o    = 1'b0;
      update_rdy_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept = 1'b1;
               if (!tlb_en_i) begin
                  state_d = ST_RESP;
                  paddr_d = req_vaddr_i[L15_PADDR_HI:0];
                  error_d = 1'b0;
               end else begin
                  state_d = ST_LOOKUP;
               end
            end
         end
         ST_LOOKUP: begin
            tlb_access_o = 1'b1;
            tlb_hit_o    = lookup_hit;
            if (lookup_hit) begin
               state_d = ST_RESP;
               paddr_d = paddr_e[hit_idx];
               error_d = 1'b0;
            end else begin
               state_d = ST_WALK;
            end
         end
         ST_WALK: begin
            update_rdy_o = 1'b1;
            if (update_valid_i) begin
               state_d = ST_LOOKUP;
            end else if (ptw_error_i) begin
               state_d = ST_RESP;
               paddr_d = '0;
               error_d = 1'b1;
            end
         end
         ST_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            update_rdy_o = 1'b1;
            if (!ptw_active_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) begin
         accept = 1'b0;
         if ((state_q == ST_LOOKUP || state_q == ST_WALK) && ptw_active_i) state_d = ST_DRAIN;
         else                                                            state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         vaddr_q    <= '0;
         is_store_q <= 1'b0;
         asid_q     <= '0;
         paddr_q    <= '0;
         error_q    <= 1'b0;
         rr_q       <= '0;
         for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
      end else begin
         state_q <= state_d;
         paddr_q <= paddr_d;
         error_q <= error_d;
         if (accept) begin
            vaddr_q    <= req_vaddr_i;
            is_store_q <= req_is_store_i;
            asid_q     <= ASID_MAX'(asid_i);
         end
         if (flush_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i].valid <= 1'b0;
         end else if (fill_en) begin
            tlb_q[victim] <= '{valid:   1'b1,
                               asid:    ASID_MAX'(update_asid_i),
                               vpn:     update_vpn_i,
                               size:    update_size_i,
                               content: update_content_i};
            if (full) rr_q <= rr_q + 1'b1;
         end
      end
   end

   assign resp_paddr_o = paddr_q;
   assign resp_error_o = error_q;
   assign tlb_vaddr_o  = vaddr_q;
   assign is_store_o   = is_store_q;

endmodule

// File: tb/tb_io_tlb.sv
module tb_io_tlb;

   localparam int NE = 8;
   localparam int NV = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          flush_i, tlb_en_i;
   logic [0:0]    asid_i;
   logic          req_valid_i, req_ready_o;
   logic [63:0]   req_vaddr_i;
   logic          req_is_store_i;
   logic          resp_valid_o, resp_ready_i;
   logic [39:0]   resp_paddr_o;
   logic          resp_error_o;
   logic          tlb_access_o, tlb_hit_o;
   logic [63:0]   tlb_vaddr_o;
   logic          is_store_o, update_rdy_o, update_valid_i;
   logic [1:0]    update_size_i;
   logic [26:0]   update_vpn_i;
   logic [0:0]    update_asid_i;
   logic [37:0]   update_content_i;
   logic          ptw_active_i, ptw_error_i;

   io_tlb #(.TLB_ENTRIES(NE), .ASID_WIDTH(1), .VADDR(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .tlb_en_i(tlb_en_i), .asid_i(asid_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vaddr_i(req_vaddr_i),
      .req_is_store_i(req_is_store_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_paddr_o(resp_paddr_o), .resp_error_o(resp_error_o), .tlb_access_o(tlb_access_o),
      .tlb_hit_o(tlb_hit_o), .tlb_vaddr_o(tlb_vaddr_o), .is_store_o(is_store_o),
      .update_rdy_o(update_rdy_o), .update_valid_i(update_valid_i), .update_size_i(update_size_i),
      .update_vpn_i(update_vpn_i), .update_asid_i(update_asid_i), .update_content_i(update_content_i),
      .ptw_active_i(ptw_active_i), .ptw_error_i(ptw_error_i)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- reference model: plain arrays + shift arithmetic ----------------
   bit          m_valid [NE];
   logic [26:0] m_vpn   [NE];
   logic [1:0]  m_size  [NE];
   logic [27:0] m_ppn   [NE];
   logic [9:0]  m_flg   [NE];
   int          m_asid  [NE];
   int          m_rr;

   function automatic int page_shift(input logic [1:0] sz);
      if (sz[1])      return 18;
      else if (sz[0]) return 9;
      return 0;
   endfunction

   function automatic void m_lookup(input logic [63:0] va, input int asid, input bit st,
                                    output bit hit, output logic [39:0] pa);
      longint unsigned vpn, off_mask, base;
      int sh;
      vpn = (va >> 12) & 64'h7FF_FFFF;
      hit = 1'b0;
      pa  = '0;
      for (int i = 0; i < NE; i++) begin
         sh = page_shift(m_size[i]);
         if (m_valid[i] && (m_asid[i] == asid || m_flg[i][5]) &&
             ((vpn >> sh) == (64'(m_vpn[i]) >> sh))) begin
            hit      = !(st && !(m_flg[i][2] && m_flg[i][7]));
            off_mask = (64'd1 << (12 + sh)) - 1;
            base     = (64'(m_ppn[i]) >> sh) << (12 + sh);
            pa       = 40'(base | (va & off_mask));
            return;
         end
      end
   endfunction

   function automatic void m_fill(input logic [26:0] vpn, input logic [1:0] sz,
                                  input logic [27:0] ppn, input logic [9:0] flg, input int asid);
      int v;
      v = -1;
      for (int i = NE - 1; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) begin
         v    = m_rr;
         m_rr = (m_rr + 1) % NE;
      end
      m_valid[v] = 1'b1;
      m_vpn[v]   = vpn;
      m_size[v]  = sz;
      m_ppn[v]   = ppn;
      m_flg[v]   = flg;
      m_asid[v]  = asid;
   endfunction

   function automatic void m_flush();
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
   endfunction

   // ---------------- one device request, bench plays the PTW ----------------
   task automatic run_req(input logic [63:0] va, input bit st, input bit en,
                          input logic [1:0] fsz, input logic [27:0] fppn, input logic [9:0] fflg,
                          input bit perr,
                          output logic [39:0] act_pa, output bit act_err, output int act_walks);
      bit          hit;
      bit          err;
      logic [39:0] pa;
      int          holds;
      err       = 1'b0;
      act_walks = 0;
      pa        = '0;
      tlb_en_i       = en;
      req_vaddr_i    = va;
      req_is_store_i = st;
      req_valid_i    = 1'b1;
      chk("req_ready", req_ready_o, 1);
      step();
      req_valid_i = 1'b0;
      if (!en) begin
         pa = va[39:0];
         chk("bypass_no_access", tlb_access_o, 0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            m_lookup(va, int'(asid_i), st, hit, pa);
            chk("lookup_access", tlb_access_o, 1);
            chk("lookup_hit", tlb_hit_o, hit);
            chk("lookup_vaddr", tlb_vaddr_o, va);
            chk("lookup_store", is_store_o, st);
            chk("lookup_no_rdy", update_rdy_o, 0);
            step();
            if (hit) break;
            act_walks++;
            chk("walk_rdy", update_rdy_o, 1);
            chk("walk_no_access", tlb_access_o, 0);
            chk("walk_no_resp", resp_valid_o, 0);
            if (perr || k > 0) begin
               ptw_error_i = 1'b1;
               step();
               ptw_error_i = 1'b0;
               err = 1'b1;
               break;
            end
            update_valid_i   = 1'b1;
            update_size_i    = fsz;
            update_vpn_i     = va[38:12];
            update_asid_i    = asid_i;
            update_content_i = {fppn, fflg};
            step();
            update_valid_i = 1'b0;
            m_fill(va[38:12], fsz, fppn, fflg, int'(asid_i));
         end
      end
      act_pa  = resp_paddr_o;
      act_err = resp_error_o;
      holds   = $urandom_range(0, 2);
      for (int h = 0; h <= holds; h++) begin
         chk("resp_valid", resp_valid_o, 1);
         chk("resp_error", resp_error_o, err);
         if (!err) chk("resp_paddr", resp_paddr_o, pa);
         chk("resp_no_rdy", update_rdy_o, 0);
         if (h == holds) resp_ready_i = 1'b1;
         step();
      end
      resp_ready_i = 1'b0;
      chk("resp_done", resp_valid_o, 0);
      chk("back_idle", req_ready_o, 1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [63:0] va;
      bit          st;
      bit          en;
      logic [1:0]  fsz;
      logic [27:0] ppn;
      logic [9:0]  flg;
      bit          perr;
      logic [39:0] exp_pa;
      bit          exp_err;
      int          exp_walks;
   } vec_t;

   vec_t        vecs [NV];
   logic [39:0] apa;
   bit          aerr;
   int          aw;
   logic [63:0] va_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{64'h0040_2123,     0, 1, 2'b00, 28'h001_2345, 10'h0CF, 0, 40'h00_1234_5123, 0, 1};
      vecs[1] = '{64'h0040_2123,     0, 1, 2'b00, 28'h000_0000, 10'h0CF, 0, 40'h00_1234_5123, 0, 0};
      vecs[2] = '{64'h7654_3210,     0, 1, 2'b10, 28'h100_0000, 10'h0CF, 0, 40'h10_3654_3210, 0, 1};
      vecs[3] = '{64'h0080_0456,     0, 1, 2'b00, 28'h000_0ABC, 10'h0C3, 0, 40'h00_00AB_C456, 0, 1};
      vecs[4] = '{64'h0080_0456,     1, 1, 2'b00, 28'h000_0000, 10'h000, 1, 40'h00_0000_0000, 1, 1};
      vecs[5] = '{64'hAB_CDEF_0123,  0, 0, 2'b00, 28'h000_0000, 10'h000, 0, 40'hAB_CDEF_0123, 0, 0};
      vecs[6] = '{64'h0040_2987,     1, 1, 2'b00, 28'h000_0000, 10'h000, 0, 40'h00_1234_5987, 0, 0};
      vecs[7] = '{64'h7FFF_FFFC,     0, 1, 2'b00, 28'h000_0000, 10'h000, 0, 40'h10_3FFF_FFFC, 0, 0};

      rst_ni = 1'b0;
      flush_i = 0; tlb_en_i = 1; asid_i = 0; req_valid_i = 0; req_vaddr_i = '0;
      req_is_store_i = 0; resp_ready_i = 0; update_valid_i = 0; update_size_i = '0;
      update_vpn_i = '0; update_asid_i = '0; update_content_i = '0;
      ptw_active_i = 0; ptw_error_i = 0;
      m_flush();
      m_rr = 0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_resp_paddr", resp_paddr_o, 0);
      chk("rst_resp_error", resp_error_o, 0);
      chk("rst_access", tlb_access_o, 0);
      chk("rst_hit", tlb_hit_o, 0);
      chk("rst_vaddr", tlb_vaddr_o, 0);
      chk("rst_store", is_store_o, 0);
      chk("rst_update_rdy", update_rdy_o, 0);
      rst_ni = 1'b1;
      step();

      for (int i = 0; i < NV; i++) begin
         run_req(vecs[i].va, vecs[i].st, vecs[i].en, vecs[i].fsz, vecs[i].ppn, vecs[i].flg,
                 vecs[i].perr, apa, aerr, aw);
         if (!vecs[i].exp_err) chk($sformatf("vec%0d_paddr", i), apa, vecs[i].exp_pa);
         chk($sformatf("vec%0d_error", i), aerr, vecs[i].exp_err);
         chk($sformatf("vec%0d_walks", i), aw, vecs[i].exp_walks);
      end

      // Capacity: flush, 9 distinct 4K fills, 9th evicts entry 0.
      flush_i = 1'b1; step(); flush_i = 1'b0; m_flush();
      for (int i = 0; i < 9; i++) begin
         va_t = 64'(27'h100 + 27'(i)) << 12;
         run_req(va_t, 0, 1, 2'b00, 28'h200 + 28'(i), 10'h0CF, 0, apa, aerr, aw);
         chk("cap_fill_walk", aw, 1);
      end
      run_req(64'h0010_1000, 0, 1, 2'b00, 28'h0, 10'h0CF, 0, apa, aerr, aw);
      chk("cap_keep_page1", aw, 0);
      chk("cap_keep_paddr", apa, 40'h00_0020_1000);
      run_req(64'h0010_0000, 0, 1, 2'b00, 28'h300, 10'h0CF, 0, apa, aerr, aw);
      chk("cap_evict_page0", aw, 1);

      // Flush mid-walk with the PTW still busy: DRAIN, no response, fills ignored.
      tlb_en_i = 1; req_is_store_i = 0; req_vaddr_i = 64'h0000_5000; req_valid_i = 1;
      step(); req_valid_i = 0;
      chk("fw_lookup_miss", tlb_hit_o, 0);
      step();
      chk("fw_walk", update_rdy_o, 1);
      flush_i = 1; ptw_active_i = 1;
      step();
      flush_i = 0; m_flush();
      update_valid_i = 1; update_size_i = 2'b00; update_vpn_i = 27'h5;
      update_asid_i = 0; update_content_i = {28'h777, 10'h0CF};
      for (int j = 0; j < 3; j++) begin
         chk("fw_drain_rdy", update_rdy_o, 1);
         chk("fw_drain_no_resp", resp_valid_o, 0);
         chk("fw_drain_not_ready", req_ready_o, 0);
         chk("fw_drain_no_access", tlb_access_o, 0);
         step();
      end
      ptw_active_i = 0; update_valid_i = 0;
      chk("fw_drain_hold", update_rdy_o, 1);
      step();
      chk("fw_idle", req_ready_o, 1);
      chk("fw_idle_rdy", update_rdy_o, 0);
      chk("fw_idle_no_resp", resp_valid_o, 0);
      run_req(64'h0000_5000, 0, 1, 2'b00, 28'h555, 10'h0CF, 0, apa, aerr, aw);
      chk("fw_next_miss", aw, 1);

      // Fill arriving together with flush is discarded.
      req_vaddr_i = 64'h0000_6000; req_valid_i = 1;
      step(); req_valid_i = 0;
      step();
      chk("ff_walk", update_rdy_o, 1);
      update_valid_i = 1; update_vpn_i = 27'h6; update_size_i = 2'b00;
      update_content_i = {28'h666, 10'h0CF}; flush_i = 1;
      step();
      update_valid_i = 0; flush_i = 0; m_flush();
      chk("ff_idle", req_ready_o, 1);
      chk("ff_no_resp", resp_valid_o, 0);
      run_req(64'h0000_6000, 0, 1, 2'b00, 28'h666, 10'h0CF, 0, apa, aerr, aw);
      chk("ff_discard_miss", aw, 1);

      // Reset asserted mid-walk.
      req_vaddr_i = 64'h0000_7000; req_valid_i = 1;
      step(); req_valid_i = 0;
      step();
      chk("rw_walk", update_rdy_o, 1);
      rst_ni = 0;
      #1;
      chk("rw_req_ready", req_ready_o, 1);
      chk("rw_update_rdy", update_rdy_o, 0);
      chk("rw_access", tlb_access_o, 0);
      chk("rw_vaddr", tlb_vaddr_o, 0);
      step();
      rst_ni = 1;
      m_flush(); m_rr = 0;
      step();
      run_req(64'h0000_6000, 0, 1, 2'b00, 28'h666, 10'h0CF, 0, apa, aerr, aw);
      chk("rw_entries_gone", aw, 1);

      // Randomized traffic against the model.
      for (int r = 0; r < 200; r++) begin
         logic [26:0] vpn;
         logic [9:0]  flg;
         logic [1:0]  sz;
         int          szi;
         vpn = {7'b0, 2'($urandom_range(0, 1)), 9'($urandom_range(0, 1)), 9'($urandom_range(0, 3))};
         va_t = {25'b0, vpn, 12'($urandom)};
         asid_i = 1'($urandom_range(0, 1));
         flg = {2'b00, 1'($urandom_range(0, 3) != 0), 1'b1, 1'($urandom_range(0, 5) == 0),
                2'b00, 1'($urandom_range(0, 3) != 0), 2'b11};
         szi = $urandom_range(0, 2);
         sz  = (szi == 2) ? 2'b10 : (szi == 1 ? 2'b01 : 2'b00);
         run_req(va_t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), sz,
                 28'($urandom), flg, 1'($urandom_range(0, 9) == 0), apa, aerr, aw);
         if ($urandom_range(0, 19) == 0) begin
            flush_i = 1; step(); flush_i = 0; m_flush();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
